// File: rtl/div_rem_sequencer_pkg.sv
// Shared constants for the M-extension divide/remainder path: ALU op codes
// and the sequencer state encoding.
package div_rem_sequencer_pkg;

  localparam logic [4:0] ALU_DIV_SLOW = 5'd20;
  localparam logic [4:0] ALU_REM_SLOW = 5'd21;
  localparam logic [4:0] ALU_DIV_FAST = 5'd22;
  localparam logic [4:0] ALU_REM_FAST = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_rem_datapath.sv
// Restoring divider datapath: magnitude shift registers, trial subtractor,
// sign fixup with divide-by-zero/overflow overrides, and the one-entry cache.
module div_rem_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            cache_wr,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            op_rem,
  output logic            kind_rem,
  output logic [XLEN-1:0] fix_q,
  output logic [XLEN-1:0] fix_r,
  output logic            cache_valid,
  output logic [XLEN-1:0] cache_a,
  output logic [XLEN-1:0] cache_b,
  output logic [XLEN-1:0] cache_q,
  output logic [XLEN-1:0] cache_r
);

  localparam logic signed [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic signed [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] mag_b, quo;
  logic [XLEN:0]   rem, rem_sh, diff;
  logic            sign_q, sign_r;

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
    diff   = rem_sh - {1'b0, mag_b};
  end

  // Operand latch and one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    if (load) begin
      a_q      <= in_a;
      b_q      <= in_b;
      mag_b    <= abs_val(in_b);
      quo      <= abs_val(in_a);
      rem      <= '0;
      sign_q   <= in_a[XLEN-1] ^ in_b[XLEN-1];
      sign_r   <= in_a[XLEN-1];
      kind_rem <= op_rem;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem <= diff;
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= rem_sh;
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    fix_q = negate_if(quo, sign_q);
    fix_r = negate_if(rem[XLEN-1:0], sign_r);
    if (b_q == '0) begin
      fix_q = '1;
      fix_r = a_q;
    end else if (a_q == MIN_NEG && b_q == '1) begin
      fix_q = MIN_NEG;
      fix_r = '0;
    end
  end

  // Cache contents are meaningless until cache_valid, so only the flag resets
  always_ff @(posedge clk) begin
    if (cache_wr) begin
      cache_a <= a_q;
      cache_b <= b_q;
      cache_q <= fix_q;
      cache_r <= fix_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cache_valid <= 1'b0;
    else if (cache_wr) cache_valid <= 1'b1;
  end

endmodule

// File: rtl/div_rem_sequencer.sv
// Divide/remainder sequencer: accepts DIV/REM ops from EXECUTE, stalls the
// pipeline through a 32-step divide, and serves FAST ops from the cache.
module div_rem_sequencer
  import div_rem_sequencer_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      in_alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_flush,
  output logic            out_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_busy
);

  localparam int CW = $clog2(ITER);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div_op, is_fast, op_rem, accept, hit, start_slow;
  logic            load, step, cache_wr, kind_rem, cache_valid;
  logic [XLEN-1:0] fix_q, fix_r, cache_a, cache_b, cache_q, cache_r;

  always_comb begin
    is_div_op  = (in_alu_op == ALU_DIV_SLOW) || (in_alu_op == ALU_REM_SLOW) ||
                 (in_alu_op == ALU_DIV_FAST) || (in_alu_op == ALU_REM_FAST);
    is_fast    = (in_alu_op == ALU_DIV_FAST) || (in_alu_op == ALU_REM_FAST);
    op_rem     = (in_alu_op == ALU_REM_SLOW) || (in_alu_op == ALU_REM_FAST);
    // A flush in the same cycle squashes the op before it is accepted
    accept     = (state == S_IDLE) && in_valid && is_div_op && !in_flush;
    hit        = accept && is_fast && cache_valid && (in_a == cache_a) && (in_b == cache_b);
    start_slow = accept && !hit;
    load       = start_slow;
    step       = (state == S_CALC) && !in_flush;
    cache_wr   = (state == S_FIXUP) && !in_flush;
    out_stall  = start_slow || (state == S_CALC) || (state == S_FIXUP);
    out_busy   = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hit) begin
            out_valid  <= 1'b1;
            out_result <= op_rem ? cache_r : cache_q;
          end else if (start_slow) begin
            cnt   <= '0;
            state <= (in_b == '0) ? S_FIXUP : S_CALC;
          end
        end
        S_CALC: begin
          if (in_flush) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITER - 1)) state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (in_flush) begin
            state <= S_IDLE;
          end else begin
            out_valid  <= 1'b1;
            out_result <= kind_rem ? fix_r : fix_q;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  div_rem_datapath #(.XLEN(XLEN)) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .cache_wr    (cache_wr),
    .in_a        (in_a),
    .in_b        (in_b),
    .op_rem      (op_rem),
    .kind_rem    (kind_rem),
    .fix_q       (fix_q),
    .fix_r       (fix_r),
    .cache_valid (cache_valid),
    .cache_a     (cache_a),
    .cache_b     (cache_b),
    .cache_q     (cache_q),
    .cache_r     (cache_r)
  );

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Directed bench for div_rem_sequencer: slow/fast ops, sign cases,
// divide-by-zero, overflow, flush and mid-operation reset.
module tb_div_rem_sequencer;
  import div_rem_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_alu_op;
  logic [31:0] in_a, in_b;
  logic        in_flush;
  logic        out_stall, out_valid, out_busy;
  logic [31:0] out_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_rem_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_alu_op  (in_alu_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_flush   (in_flush),
    .out_stall  (out_stall),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_busy   (out_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a cycle, then time its result pulse from the accept edge.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat,
                        input logic exp_stall);
    int   k;
    logic found, stall_ok;
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = op; in_a = a; in_b = b;
    #1 chk({tag, "_accept_stall"}, 32'(out_stall), 32'(exp_stall));
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0; found = 1'b0; stall_ok = 1'b1;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (out_valid) found = 1'b1;
      else if (!out_stall) stall_ok = 1'b0;
    end
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    chk({tag, "_result"}, out_result, res);
    chk({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_at_valid"}, 32'(out_stall), 32'd0);
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_after"}, 32'(out_busy), 32'd0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; in_alu_op = '0; in_a = '0; in_b = '0; in_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(out_stall), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_100_7",   ALU_DIV_SLOW, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    run_op("remf_100_7",  ALU_REM_FAST, 32'd100, 32'd7, 32'd2,  1,  1'b0);
    run_op("divf_100_7",  ALU_DIV_FAST, 32'd100, 32'd7, 32'd14, 1,  1'b0);
    run_op("rem_m7_2",    ALU_REM_SLOW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
    run_op("div_m7_2",    ALU_DIV_SLOW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
    run_op("div_7_m2",    ALU_DIV_SLOW, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b1);
    run_op("div_5_0",     ALU_DIV_SLOW, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b1);
    run_op("remf_5_0",    ALU_REM_FAST, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div_ovf",     ALU_DIV_SLOW, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b1);
    run_op("remf_ovf",    ALU_REM_FAST, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_op("rem_ovf",     ALU_REM_SLOW, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b1);

    // Non-divide op must be ignored
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = 5'd3; in_a = 32'd100; in_b = 32'd7;
    #1 chk("other_op_stall", 32'(out_stall), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("other_op_valid", 32'(out_valid), 32'd0);
    chk("other_op_busy", 32'(out_busy), 32'd0);

    // Flush at CALC step 10
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = ALU_DIV_SLOW; in_a = 32'd9; in_b = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", 32'(out_busy), 32'd1);
    in_flush = 1'b1;
    @(posedge clk);
    #1 in_flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(out_stall), 32'd0);
    chk("flush_busy", 32'(out_busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op("divf_9_3_miss", ALU_DIV_FAST, 32'd9, 32'd3, 32'd3, 34, 1'b1);

    // Flush together with an accept drops the op
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = ALU_DIV_SLOW; in_a = 32'd50; in_b = 32'd5; in_flush = 1'b1;
    #1 chk("flush_accept_stall", 32'(out_stall), 32'd0);
    @(posedge clk);
    #1 begin in_valid = 1'b0; in_flush = 1'b0; end
    @(negedge clk);
    chk("flush_accept_busy", 32'(out_busy), 32'd0);

    // Asynchronous reset in CALC clears everything, including the cache
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = ALU_DIV_SLOW; in_a = 32'd20; in_b = 32'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(out_stall), 32'd0);
    chk("arst_busy", 32'(out_busy), 32'd0);
    chk("arst_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divf_after_rst", ALU_DIV_FAST, 32'd9, 32'd3, 32'd3, 34, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
